// File: rtl/adc_readout_arbiter.sv
// Round-robin readout arbiter: grants one ADC capture buffer at a time and streams
// its 128-bit words as a header beat followed by four 32-bit AXI-Stream beats per word.
module adc_readout_arbiter #(
    parameter int NUM_CH = 16,
    parameter int DATA_W = 128,
    parameter int LEN_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*LEN_W-1:0]  ch_len,
    input  logic [NUM_CH*DATA_W-1:0] ch_rd_data,
    output logic [NUM_CH-1:0]        ch_grant,
    output logic                     ch_rd_en,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [31:0]              m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     busy,
    output logic [2:0]               dbg_state
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {IDLE, ARB, HDR, FETCH, WAIT, SEND, DONE} state_t;

    state_t            state, state_nxt;
    logic [CH_W-1:0]   ptr, ch_idx, arb_idx;
    logic              arb_hit;
    logic [LEN_W-1:0]  len_lat, len_cnt;
    logic [DATA_W-1:0] hold;
    logic [1:0]        beat_idx;
    logic              tvalid_q;
    logic              hs;
    int                k;

    // Valid/ready: a beat transfers on a rising edge where tvalid and tready are both
    // high; once tvalid rises, tdata/tlast stay frozen until that transfer happens.
    assign hs        = tvalid_q && m_axis_tready;
    assign dbg_state = state;

    // First requester at or above the pointer; descending loop lets the nearest win.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        k       = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % NUM_CH;
            if (ch_req[CH_W'(k)]) begin
                arb_hit = 1'b1;
                arb_idx = CH_W'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (enable && (ch_req != '0)) state_nxt = ARB;
            ARB:   state_nxt = arb_hit ? HDR : IDLE;
            HDR:   if (hs) state_nxt = (len_lat == '0) ? DONE : FETCH;
            FETCH: state_nxt = WAIT;
            WAIT:  state_nxt = SEND;
            SEND:  if (hs && beat_idx == 2'd3)
                       state_nxt = (len_cnt == LEN_W'(1)) ? DONE : FETCH;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            ch_idx   <= '0;
            len_lat  <= '0;
            len_cnt  <= '0;
            hold     <= '0;
            beat_idx <= '0;
            tvalid_q <= 1'b0;
        end else begin
            tvalid_q <= (state_nxt == HDR) || (state_nxt == SEND);
            case (state)
                ARB: if (arb_hit) begin
                    ch_idx  <= arb_idx;
                    len_lat <= ch_len[arb_idx*LEN_W +: LEN_W];
                    len_cnt <= ch_len[arb_idx*LEN_W +: LEN_W];
                end
                WAIT: begin
                    hold     <= ch_rd_data[ch_idx*DATA_W +: DATA_W];
                    beat_idx <= 2'd0;
                end
                SEND: if (hs) begin
                    beat_idx <= beat_idx + 2'd1;
                    if (beat_idx == 2'd3) len_cnt <= len_cnt - 1'b1;
                end
                DONE: ptr <= (ch_idx == CH_W'(NUM_CH - 1)) ? '0 : ch_idx + 1'b1;
                default: ;
            endcase
        end
    end

    // Beat payload and sideband decode purely from registers, so they cannot move
    // while a beat is stalled.
    always_comb begin
        ch_grant      = '0;
        ch_done       = '0;
        ch_rd_en      = (state == FETCH);
        busy          = (state != IDLE);
        m_axis_tvalid = tvalid_q;
        m_axis_tdata  = 32'h0;
        m_axis_tlast  = 1'b0;
        if (state inside {HDR, FETCH, WAIT, SEND, DONE}) ch_grant[ch_idx] = 1'b1;
        if (state == DONE) ch_done[ch_idx] = 1'b1;
        if (state == HDR) begin
            m_axis_tdata = {8'hA5, 4'h0, 4'(ch_idx), 16'(len_lat)};
            m_axis_tlast = (len_lat == '0);
        end else if (state == SEND) begin
            m_axis_tdata = hold[beat_idx*32 +: 32];
            m_axis_tlast = (beat_idx == 2'd3) && (len_cnt == LEN_W'(1));
        end
    end

endmodule

// File: tb/tb_adc_readout_arbiter.sv
// Randomized bench for adc_readout_arbiter: a packet-level round-robin model fills an
// expected-beat queue that every accepted beat and every ch_done pulse is checked against.
module tb_adc_readout_arbiter;
    localparam int NCH = 16;
    localparam int DW  = 128;
    localparam int LW  = 16;
    localparam int W   = 33;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [NCH-1:0]    ch_req;
    logic [NCH*LW-1:0] ch_len;
    logic [NCH*DW-1:0] ch_rd_data;
    logic [NCH-1:0]    ch_grant;
    logic              ch_rd_en;
    logic [NCH-1:0]    ch_done;
    logic [31:0]       m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic              busy;
    logic [2:0]        dbg_state;

    adc_readout_arbiter #(.NUM_CH(NCH), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .ch_req(ch_req), .ch_len(ch_len),
        .ch_rd_data(ch_rd_data), .ch_grant(ch_grant), .ch_rd_en(ch_rd_en),
        .ch_done(ch_done), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .busy(busy),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard and model state
    logic [W-1:0]  exp_q[$];
    int            exp_ch_q[$];
    int            exp_rd_q[$];
    logic [DW-1:0] mem [NCH][256];
    int            up_rd [NCH];
    int            mdl_rd [NCH];
    int            lens [NCH];
    int            m_ptr;
    int            n_checks = 0;
    int            n_bad = 0;
    int            beat_scn, done_scn;
    int            rdy_mode, stall_cnt;
    bit            en_rand;
    logic          prev_stall;
    logic [W-1:0]  prev_beat;

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int oh_idx(logic [NCH-1:0] v);
        oh_idx = -1;
        if ($onehot(v))
            for (int i = 0; i < NCH; i++) if (v[i]) oh_idx = i;
    endfunction

    task automatic add_pkt(int c, int len);
        logic [DW-1:0] word;
        logic [3:0]    c4;
        logic [15:0]   l16;
        logic          last;
        c4   = c[3:0];
        l16  = len[15:0];
        last = (len == 0);
        exp_q.push_back({last, 8'hA5, 4'h0, c4, l16});
        for (int w = 0; w < len; w++) begin
            word = mem[c][(mdl_rd[c] + w) % 256];
            for (int b = 0; b < 4; b++) begin
                last = (w == len - 1) && (b == 3);
                exp_q.push_back({last, word[b*32 +: 32]});
            end
        end
        mdl_rd[c] += len;
    endtask

    // Packet-level round robin: serve the first pending channel from the pointer, then
    // move the pointer past it, until every requested channel has been served once.
    task automatic plan(logic [NCH-1:0] req);
        logic [NCH-1:0] r;
        int c, k;
        for (int i = 0; i < NCH; i++) ch_len[i*LW +: LW] = LW'(lens[i]);
        r = req;
        while (r != '0) begin
            c = -1;
            for (int i = 0; i < NCH; i++) begin
                k = (m_ptr + i) % NCH;
                if (c < 0 && r[k]) c = k;
            end
            add_pkt(c, lens[c]);
            exp_ch_q.push_back(c);
            exp_rd_q.push_back(mdl_rd[c]);
            r[c]  = 1'b0;
            m_ptr = (c + 1) % NCH;
        end
        ch_req = ch_req | req;
    endtask

    // One cycle: drive tready/enable on the falling edge, then check what the next
    // rising edge will accept.
    task automatic step();
        logic [W-1:0]   got, exp;
        logic [NCH-1:0] one;
        int c, r;
        @(negedge clk);
        one = 16'h1;
        case (rdy_mode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = ($urandom_range(0, 3) != 0);
            default: begin
                if (stall_cnt > 0) begin
                    m_axis_tready = 1'b0;
                    stall_cnt--;
                end else m_axis_tready = 1'b1;
            end
        endcase
        if (en_rand) enable = ($urandom_range(0, 9) < 7);
        if (rst) begin
            got = {m_axis_tlast, m_axis_tdata};
            if (prev_stall) begin
                check("stall_valid", m_axis_tvalid, 1'b1);
                check("stall_beat", got, prev_beat);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                check("beat", got, exp);
                if (exp_ch_q.size() > 0) check("grant_beat", ch_grant, one << exp_ch_q[0]);
                beat_scn++;
                if (rdy_mode == 2 && beat_scn % 5 == 0) stall_cnt = 20;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = got;
            if (ch_done != '0) begin
                if (exp_ch_q.size() == 0) check("unexpected_done", ch_done, 0);
                else begin
                    c = exp_ch_q.pop_front();
                    r = exp_rd_q.pop_front();
                    check("done_ch", ch_done, one << c);
                    check("grant_at_done", ch_grant, one << c);
                    check("pops", up_rd[c], r);
                    ch_req[c] = 1'b0;
                    done_scn++;
                end
            end
        end else prev_stall = 1'b0;
    endtask

    task automatic run_scn(int max_cyc);
        int n = 0;
        while ((exp_ch_q.size() != 0 || busy) && n < max_cyc) begin
            step();
            n++;
        end
        check("scn_timeout", n < max_cyc, 1'b1);
        check("leftover_beats", exp_q.size(), 0);
    endtask

    task automatic check_idle(string tag);
        check({tag, "_grant"}, ch_grant, 0);
        check({tag, "_rd_en"}, ch_rd_en, 0);
        check({tag, "_done"}, ch_done, 0);
        check({tag, "_tvalid"}, m_axis_tvalid, 0);
        check({tag, "_tlast"}, m_axis_tlast, 0);
        check({tag, "_tdata"}, m_axis_tdata, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Upstream buffer: a pop presents the popped word one cycle later, junk otherwise.
    initial begin
        int c;
        logic [DW-1:0] w;
        for (int i = 0; i < NCH; i++)
            ch_rd_data[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && ch_rd_en) begin
                c = oh_idx(ch_grant);
                check("pop_grant_onehot", $onehot(ch_grant), 1'b1);
                if (c >= 0) begin
                    w = mem[c][up_rd[c] % 256];
                    up_rd[c]++;
                    @(posedge clk);
                    #1 ch_rd_data[c*DW +: DW] = w;
                    @(posedge clk);
                    #1 ch_rd_data[c*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, cyc, n;
        logic [NCH-1:0] one;
        logic [DW-1:0]  word1;
        one   = 16'h1;
        word1 = 128'h1000_2000_3000_4000_5000_6000_7000_8000;
        rst = 1'b0; enable = 1'b0; ch_req = '0; ch_len = '0; m_axis_tready = 1'b1;
        rdy_mode = 0; stall_cnt = 0; en_rand = 0; prev_stall = 1'b0; prev_beat = '0;
        m_ptr = 0; beat_scn = 0; done_scn = 0;
        for (int i = 0; i < NCH; i++) begin
            up_rd[i] = 0; mdl_rd[i] = 0; lens[i] = 0;
            for (int j = 0; j < 256; j++) mem[i][j] = {$urandom, $urandom, $urandom, $urandom};
        end
        repeat (3) step();
        check_idle("reset");
        rst = 1'b1; enable = 1'b1;
        step();

        // every channel requesting, one word each: strict 0..15 order
        for (int i = 0; i < NCH; i++) lens[i] = 1;
        beat_scn = 0; done_scn = 0;
        plan(16'hFFFF);
        run_scn(800);
        check("all16_beats", beat_scn, 80);
        check("all16_done", done_scn, 16);

        // single channel 0, two known words, header latency
        mem[0][up_rd[0] % 256]       = word1;
        mem[0][(up_rd[0] + 1) % 256] = word1;
        lens[0] = 2; beat_scn = 0; done_scn = 0;
        plan(16'h0001);
        cyc = 1;
        while (!m_axis_tvalid && cyc < 20) begin step(); cyc++; end
        check("hdr_latency", cyc, 3);
        check("hdr_word", m_axis_tdata, 32'hA500_0002);
        run_scn(200);
        check("ch0_beats", beat_scn, 9);
        check("ch0_done", done_scn, 1);

        // zero-length packet on channel 7
        lens[7] = 0; beat_scn = 0; done_scn = 0;
        plan(one << 7);
        run_scn(100);
        check("len0_beats", beat_scn, 1);
        check("len0_done", done_scn, 1);

        // wrap: park the pointer at 14, then 15 before 3, then 5 before 2
        lens[13] = 1; plan(one << 13); run_scn(100);
        lens[3] = $urandom_range(0, 2); lens[15] = $urandom_range(0, 2);
        plan(16'h8008); run_scn(200);
        lens[2] = 1; lens[5] = 1;
        plan(16'h0024); run_scn(200);

        // enable low holds off arbitration
        enable = 1'b0; lens[4] = 1;
        plan(one << 4);
        repeat (10) step();
        check("en_gate_busy", busy, 0);
        check("en_gate_valid", m_axis_tvalid, 0);
        enable = 1'b1;
        run_scn(200);

        // backpressure: 20 stalled cycles after every 5th beat
        c = $urandom_range(0, NCH - 1);
        lens[c] = 16; rdy_mode = 2; stall_cnt = 0; beat_scn = 0;
        plan(one << c);
        run_scn(3000);
        check("bp_beats", beat_scn, 65);
        rdy_mode = 0;

        // random request sets, lengths, tready and enable
        for (int r = 0; r < 6; r++) begin
            rdy_mode = 1; en_rand = 1;
            for (int i = 0; i < NCH; i++) lens[i] = $urandom_range(0, 3);
            plan(NCH'($urandom_range(1, 16'hFFFF)));
            run_scn(3000);
        end
        en_rand = 0; enable = 1'b1; rdy_mode = 0;

        // reset in the middle of SEND, then the request restarts with a fresh header
        lens[9] = 3; beat_scn = 0;
        plan(one << 9);
        n = 0;
        while (beat_scn < 3 && n < 100) begin step(); n++; end
        check("reach_send", beat_scn, 3);
        rst = 1'b0;
        #1 check_idle("rst_mid");
        exp_q.delete(); exp_ch_q.delete(); exp_rd_q.delete();
        m_ptr = 0; mdl_rd[9] = up_rd[9];
        repeat (3) step();
        plan(one << 9);
        rst = 1'b1; beat_scn = 0; done_scn = 0;
        run_scn(200);
        check("restart_beats", beat_scn, 13);
        check("restart_done", done_scn, 1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule

// File: doc/adc_readout_arbiter.md
# adc_readout_arbiter

Round-robin scheduler that shares the single 32-bit AXI-Stream readout path to the PS among the 16 ADC capture buffers. It grants one channel at a time and pops its 128-bit capture words. Each word is serialized into four 32-bit beats behind a one-beat header, and the grant is released only after the whole packet has been accepted. It sits between the per-channel ADC capture drivers and the PS-facing adc_axis port of the PL controller.

## Interface
- NUM_CH, 16, number of ADC requesters (power of two, ≤16)
- DATA_W, 128, capture word width (8 × 16-bit samples)
- LEN_W, 16, width of per-channel word count
- clk  in  1  PL clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  readout enable; level, sampled every cycle
- ch_req  in  NUM_CH  channel c has a completed capture; held high until ch_done[c]
- ch_len  in  NUM_CH*LEN_W  channel c's word count at bits [c*LEN_W +: LEN_W]
- ch_rd_data  in  NUM_CH*DATA_W  channel c's head-of-buffer word; valid 1 cycle after its pop
- ch_grant  out  NUM_CH  one-hot grant; zero when idle
- ch_rd_en  out  1  single-cycle pop of the granted channel's buffer
- ch_done  out  NUM_CH  one-cycle pulse when channel c's packet is fully accepted
- m_axis_tdata  out  32  readout beat
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last beat of packet
- busy  out  1  high in any state other than IDLE

## Operation
- The FSM has seven states: IDLE, ARB, HDR, FETCH, WAIT, SEND, DONE.
- IDLE → ARB when enable=1 and ch_req≠0.
- ARB: select the first set ch_req bit, searching from the round-robin pointer upward with wrap-around at NUM_CH.
  - Latch the channel index and its ch_len into len_cnt.
  - Assert ch_grant[c] from the next cycle through DONE.
  - Go to HDR.
- HDR: present header beat {8'hA5, 4'h0, ch[3:0], ch_len[15:0]}.
  - tlast=1 on the header only if len=0.
  - On handshake: if len=0 go to DONE, else go to FETCH.
- FETCH: pulse ch_rd_en for one cycle, then go to WAIT.
- WAIT: capture ch_rd_data of the granted channel into a 128-bit holding register, clear beat_idx, then go to SEND.
- SEND: m_axis_tdata = hold[beat_idx*32 +: 32], so the lowest 32 bits go first.
  - On each handshake beat_idx increments.
  - After beat 3, decrement len_cnt. If it reaches 0 go to DONE, else go to FETCH.
  - tlast=1 on beat 3 of the final word.
- DONE: pulse ch_done[c], set pointer = c+1 (mod NUM_CH), drop the grant, return to IDLE.
- enable deasserted mid-packet: the current packet completes normally; no new ARB is entered until enable=1.
- ch_req changes during a packet are ignored; requests are evaluated only in ARB.
- ch_len is sampled once in ARB. Later changes have no effect on the current packet.
- Packet length is 1 + 4×len beats.

## Timing
- Reset values: ch_grant=0, ch_rd_en=0, ch_done=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, pointer=0, state=IDLE.
- Reset mid-packet aborts immediately. No ch_done is issued and the buffer is not rewound.
- m_axis_tvalid is registered and is high only in HDR and SEND.
- While tvalid=1 and tready=0, tdata and tlast hold stable. tvalid never drops without a handshake.
- Latency from ch_req rising (in IDLE, enable=1) to header tvalid is 3 cycles: IDLE→ARB→HDR registered.
- Each word costs 2 overhead cycles (FETCH, WAIT) plus 4 SEND beats at tready=1.
- Pops per packet equal exactly len. No pop is issued for len=0.
- The upstream buffer must present its data in the cycle after the ch_rd_en pulse.
- Between packets there is a minimum of 2 idle cycles (DONE, IDLE) before the next ARB.

## Test plan
- Single channel, ch_req[0]=1, len=2, word 0x1000_2000_…_8000, tready=1.
  - Required: header 0xA5000002.
  - Then beats 0x70008000, 0x50006000, 0x30004000, 0x10002000 repeated twice.
  - tlast on beat 9 only, 2 pops, ch_done[0] pulse.
- All 16 ch_req high, len=1 each.
  - Required: grants in order 0,1,…,15, each grant one-hot.
  - 16 packets of 5 beats, 16 ch_done pulses.
- Round-robin wrap: pointer at 14, requests on channels 3 and 15.
  - Required: 15 is served first, then 3; the pointer ends at 4.
- Backpressure: tready low for 20 cycles at every 5th beat, len=16.
  - Required: no beat lost or duplicated, tdata stable while stalled, 65 beats total.
- len=0 on channel 7.
  - Required: a single header beat 0xA5070000 with tlast=1, no ch_rd_en, ch_done[7] pulse.
- Assert rst low during SEND.
  - Required: all outputs 0 in the same cycle. After release, with ch_req still high, the packet restarts from a fresh header.
